// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit.
//   state_e        - RUN / HALTED control states
//   HALT_CODE_DEF  - default a7 value that turns ecall into a halt
//   *_W            - datapath and counter widths
//   sat_inc_evt    - saturating increment for the retirement event counters
package pc_pkg;

    localparam int PC_W        = 32;
    localparam int CYC_CNT_W   = 32;
    localparam int EVT_CNT_W   = 16;

    localparam logic [PC_W-1:0] HALT_CODE_DEF = 32'd10;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [EVT_CNT_W-1:0] sat_inc_evt(input logic [EVT_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: decoded-instruction / PC bundle between the core and pc_unit.
//   master (core side): drives branch/jump/ecall flags, ALU compare results,
//                       imm, rs1_val, a7_val, stall, go; reads PC state.
//   slave  (pc_unit)  : the reverse; drives pc, pc_plus4, taken, halted and
//                       the cycle/jump/branch counters.
interface pc_unit_if;
    import pc_pkg::*;

    logic                 beq, bne, bge, jal, jalr, ecall;
    logic                 eq, lt;
    logic [PC_W-1:0]      imm, rs1_val, a7_val;
    logic                 stall, go;

    logic [PC_W-1:0]      pc, pc_plus4;
    logic                 taken, halted;
    logic [CYC_CNT_W-1:0] cycle_cnt;
    logic [EVT_CNT_W-1:0] jump_cnt, branch_cnt;

    modport master (
        output beq, bne, bge, jal, jalr, ecall, eq, lt,
               imm, rs1_val, a7_val, stall, go,
        input  pc, pc_plus4, taken, halted, cycle_cnt, jump_cnt, branch_cnt
    );

    modport slave (
        input  beq, bne, bge, jal, jalr, ecall, eq, lt,
               imm, rs1_val, a7_val, stall, go,
        output pc, pc_plus4, taken, halted, cycle_cnt, jump_cnt, branch_cnt
    );

endinterface

// File: rtl/pc_unit_branch_resolver.sv
// branch_resolver: purely combinational next-PC selection.
//   pc_i, imm_i, rs1_val_i       - current PC, immediate, jalr base
//   beq/bne/bge/jal/jalr_i       - decoded control flags
//   eq_i, lt_i                   - ALU compare results (lt is signed)
//   br_ok_o                      - conditional branch condition met
//   taken_o                      - instruction redirects the PC
//   pc_plus4_o                   - sequential PC / link value
//   next_pc_o                    - PC the instruction would retire to
// All adds are 32-bit modulo; wrap-around is intentional.
module branch_resolver
    import pc_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] imm_i,
    input  logic [PC_W-1:0] rs1_val_i,
    input  logic            beq_i,
    input  logic            bne_i,
    input  logic            bge_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    input  logic            eq_i,
    input  logic            lt_i,
    output logic            br_ok_o,
    output logic            taken_o,
    output logic [PC_W-1:0] pc_plus4_o,
    output logic [PC_W-1:0] next_pc_o
);

    logic [PC_W-1:0] pc_rel;
    logic [PC_W-1:0] jalr_tgt;

    assign br_ok_o    = (beq_i & eq_i) | (bne_i & ~eq_i) | (bge_i & ~lt_i);
    assign taken_o    = jal_i | jalr_i | br_ok_o;
    assign pc_plus4_o = pc_i + 32'd4;
    assign pc_rel     = pc_i + imm_i;
    // jalr target has bit 0 cleared so it is always halfword aligned.
    assign jalr_tgt   = (rs1_val_i + imm_i) & ~32'h1;

    always_comb begin
        next_pc_o = pc_plus4_o;
        if (jalr_i)                next_pc_o = jalr_tgt;
        else if (jal_i || br_ok_o) next_pc_o = pc_rel;
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter, RUN/HALTED control and performance counters.
//   clk, rst        - clock; synchronous active-high reset
//   bus (slave)     - decoded flags and operands in; pc, pc_plus4, taken,
//                     halted, cycle_cnt, jump_cnt, branch_cnt out
// In RUN an unstalled instruction either retires (pc advances, event
// counters update) or, for a halting ecall, parks the unit in HALTED with
// pc still pointing at the ecall. A go pulse steps past it and resumes.
module pc_unit
    import pc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [PC_W-1:0] HALT_CODE = HALT_CODE_DEF
)(
    input  logic       clk,
    input  logic       rst,
    pc_unit_if.slave   bus
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [CYC_CNT_W-1:0] cyc_q, cyc_d;
    logic [EVT_CNT_W-1:0] jmp_q, jmp_d;
    logic [EVT_CNT_W-1:0] br_q, br_d;

    logic                 br_ok;
    logic                 taken;
    logic [PC_W-1:0]      pc_plus4;
    logic [PC_W-1:0]      next_pc;
    logic                 halt_req;

    branch_resolver u_br (
        .pc_i       (pc_q),
        .imm_i      (bus.imm),
        .rs1_val_i  (bus.rs1_val),
        .beq_i      (bus.beq),
        .bne_i      (bus.bne),
        .bge_i      (bus.bge),
        .jal_i      (bus.jal),
        .jalr_i     (bus.jalr),
        .eq_i       (bus.eq),
        .lt_i       (bus.lt),
        .br_ok_o    (br_ok),
        .taken_o    (taken),
        .pc_plus4_o (pc_plus4),
        .next_pc_o  (next_pc)
    );

    assign halt_req = bus.ecall & (bus.a7_val == HALT_CODE) & ~bus.stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        jmp_d   = jmp_q;
        br_d    = br_q;
        case (state_q)
            RUN: begin
                cyc_d = cyc_q + 1'b1;
                if (!bus.stall) begin
                    // A halting ecall beats any redirect in the same word.
                    if (halt_req) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = next_pc;
                        if (bus.jal || bus.jalr) jmp_d = sat_inc_evt(jmp_q);
                        else if (br_ok)          br_d  = sat_inc_evt(br_q);
                    end
                end
            end
            HALTED: begin
                if (bus.go) begin
                    pc_d    = pc_plus4;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cyc_q   <= '0;
            jmp_q   <= '0;
            br_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
            jmp_q   <= jmp_d;
            br_q    <= br_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.taken      = taken;
    assign bus.halted     = (state_q == HALTED);
    assign bus.cycle_cnt  = cyc_q;
    assign bus.jump_cnt   = jmp_q;
    assign bus.branch_cnt = br_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table of single-instruction vectors applied from reset, then
// hand sequences for halt/resume, stall, reset priority and saturation.
// Expected register state is pushed to a scoreboard queue as each cycle's
// stimulus is driven and popped after the clock edge.
module tb_pc_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_unit_if bus ();

    pc_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [7:0] F_BEQ = 8'h80, F_BNE = 8'h40, F_BGE = 8'h20, F_JAL = 8'h10,
                           F_JALR = 8'h08, F_ECALL = 8'h04, F_EQ = 8'h02, F_LT = 8'h01;

    typedef struct {
        logic [7:0]  f;
        logic [31:0] imm, rs1, a7;
        logic        taken;
        logic [31:0] p4, nxt;
        logic [15:0] jmp, br;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        halted;
        logic [31:0] cyc;
        logic [15:0] jmp, br;
    } exp_t;

    vec_t vt [20];
    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic [7:0] f, logic [31:0] imm, logic [31:0] rs1, logic [31:0] a7,
                                logic t, logic [31:0] p4, logic [31:0] nxt,
                                logic [15:0] jmp, logic [15:0] br);
        vec_t v;
        v.f = f; v.imm = imm; v.rs1 = rs1; v.a7 = a7; v.taken = t;
        v.p4 = p4; v.nxt = nxt; v.jmp = jmp; v.br = br;
        return v;
    endfunction

    function automatic exp_t ex(logic [31:0] pc, logic h, logic [31:0] cyc,
                                logic [15:0] jmp, logic [15:0] br);
        exp_t e;
        e.pc = pc; e.halted = h; e.cyc = cyc; e.jmp = jmp; e.br = br;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic chk_state(string tag, exp_t e);
        chk({tag, ".pc"},     bus.pc,                 e.pc);
        chk({tag, ".halted"}, {31'd0, bus.halted},    {31'd0, e.halted});
        chk({tag, ".cyc"},    bus.cycle_cnt,          e.cyc);
        chk({tag, ".jmp"},    {16'd0, bus.jump_cnt},  {16'd0, e.jmp});
        chk({tag, ".br"},     {16'd0, bus.branch_cnt},{16'd0, e.br});
    endtask

    task automatic drive(logic [7:0] f, logic [31:0] imm, logic [31:0] rs1, logic [31:0] a7,
                         logic stall, logic go);
        bus.beq = f[7]; bus.bne = f[6]; bus.bge = f[5]; bus.jal = f[4];
        bus.jalr = f[3]; bus.ecall = f[2]; bus.eq = f[1]; bus.lt = f[0];
        bus.imm = imm; bus.rs1_val = rs1; bus.a7_val = a7;
        bus.stall = stall; bus.go = go;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick(string tag, exp_t e);
        exp_t got;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk_state(tag, got);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        drive(8'h00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        vt[0]  = mk(8'h00,          32'd0,        32'd0,        32'd0, 1'b0, 32'h4,   32'h4,        16'd0, 16'd0);
        vt[1]  = mk(8'h00,          32'd0,        32'd0,        32'd0, 1'b0, 32'h8,   32'h8,        16'd0, 16'd0);
        vt[2]  = mk(8'h00,          32'd0,        32'd0,        32'd0, 1'b0, 32'hC,   32'hC,        16'd0, 16'd0);
        vt[3]  = mk(F_JALR,         32'd0,        32'h8,        32'd0, 1'b1, 32'h10,  32'h8,        16'd1, 16'd0);
        vt[4]  = mk(F_BEQ|F_EQ,     32'hFFFFFFF8, 32'd0,        32'd0, 1'b1, 32'hC,   32'h0,        16'd1, 16'd1);
        vt[5]  = mk(8'h00,          32'd0,        32'd0,        32'd0, 1'b0, 32'h4,   32'h4,        16'd1, 16'd1);
        vt[6]  = mk(8'h00,          32'd0,        32'd0,        32'd0, 1'b0, 32'h8,   32'h8,        16'd1, 16'd1);
        vt[7]  = mk(F_BEQ,          32'hFFFFFFF8, 32'd0,        32'd0, 1'b0, 32'hC,   32'hC,        16'd1, 16'd1);
        vt[8]  = mk(F_JALR,         32'd4,        32'h103,      32'd0, 1'b1, 32'h10,  32'h106,      16'd2, 16'd1);
        vt[9]  = mk(F_BNE,          32'h10,       32'd0,        32'd0, 1'b1, 32'h10A, 32'h116,      16'd2, 16'd2);
        vt[10] = mk(F_BNE|F_EQ,     32'h10,       32'd0,        32'd0, 1'b0, 32'h11A, 32'h11A,      16'd2, 16'd2);
        vt[11] = mk(F_BGE,          32'hFFFFFFEA, 32'd0,        32'd0, 1'b1, 32'h11E, 32'h104,      16'd2, 16'd3);
        vt[12] = mk(F_BGE|F_LT,     32'hFFFFFFEA, 32'd0,        32'd0, 1'b0, 32'h108, 32'h108,      16'd2, 16'd3);
        vt[13] = mk(F_JAL,          32'h100,      32'd0,        32'd0, 1'b1, 32'h10C, 32'h208,      16'd3, 16'd3);
        vt[14] = mk(F_JAL|F_BEQ|F_EQ, 32'h8,      32'd0,        32'd0, 1'b1, 32'h20C, 32'h210,      16'd4, 16'd3);
        vt[15] = mk(F_JALR|F_JAL,   32'd0,        32'h301,      32'd0, 1'b1, 32'h214, 32'h300,      16'd5, 16'd3);
        vt[16] = mk(F_ECALL,        32'd0,        32'd0,        32'd5, 1'b0, 32'h304, 32'h304,      16'd5, 16'd3);
        vt[17] = mk(F_JALR,         32'd0,        32'hFFFFFFFC, 32'd0, 1'b1, 32'h308, 32'hFFFFFFFC, 16'd6, 16'd3);
        vt[18] = mk(8'h00,          32'd0,        32'd0,        32'd0, 1'b0, 32'h0,   32'h0,        16'd6, 16'd3);
        vt[19] = mk(F_JALR,         32'd2,        32'h7,        32'd0, 1'b1, 32'h4,   32'h8,        16'd7, 16'd3);

        drive(8'h00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        do_reset();
        chk_state("reset", ex(32'h0, 1'b0, 32'd0, 16'd0, 16'd0));

        // ---- table-driven single-instruction vectors ----
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].f, vt[i].imm, vt[i].rs1, vt[i].a7, 1'b0, 1'b0);
            #1;
            chk($sformatf("v%0d.taken", i), {31'd0, bus.taken}, {31'd0, vt[i].taken});
            chk($sformatf("v%0d.pc_plus4", i), bus.pc_plus4, vt[i].p4);
            tick($sformatf("v%0d", i), ex(vt[i].nxt, 1'b0, i + 1, vt[i].jmp, vt[i].br));
        end

        // ---- halt at pc=0x14, idle, resume ----
        do_reset();
        for (int i = 0; i < 5; i++) tick("seq", ex(32'h4 * (i + 1), 1'b0, i + 1, 16'd0, 16'd0));
        drive(F_ECALL, 32'd0, 32'd0, 32'd10, 1'b0, 1'b0);
        tick("halt", ex(32'h14, 1'b1, 32'd6, 16'd0, 16'd0));
        for (int i = 0; i < 5; i++) begin
            drive((i == 3) ? F_JAL : 8'h00, 32'h40, 32'd0, 32'd0, (i == 2), 1'b0);
            if (i == 3) begin
                #1;
                chk("halted.taken", {31'd0, bus.taken}, 32'd1);
            end
            tick("idle", ex(32'h14, 1'b1, 32'd6, 16'd0, 16'd0));
        end
        drive(8'h00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick("go", ex(32'h18, 1'b0, 32'd6, 16'd0, 16'd0));

        // ---- stalled halting ecall, then halt when stall drops ----
        drive(F_ECALL, 32'd0, 32'd0, 32'd10, 1'b1, 1'b0);
        tick("ecst1", ex(32'h18, 1'b0, 32'd7, 16'd0, 16'd0));
        tick("ecst2", ex(32'h18, 1'b0, 32'd8, 16'd0, 16'd0));
        drive(F_ECALL, 32'd0, 32'd0, 32'd10, 1'b0, 1'b0);
        tick("ec_halt", ex(32'h18, 1'b1, 32'd9, 16'd0, 16'd0));
        drive(8'h00, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        tick("go_stall", ex(32'h1C, 1'b0, 32'd9, 16'd0, 16'd0));
        drive(8'h00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick("go_run", ex(32'h20, 1'b0, 32'd10, 16'd0, 16'd0));
        drive(F_JAL, 32'h40, 32'd0, 32'd0, 1'b1, 1'b0);
        tick("jal_stall", ex(32'h20, 1'b0, 32'd11, 16'd0, 16'd0));
        drive(F_JAL | F_ECALL, 32'h40, 32'd0, 32'd10, 1'b0, 1'b0);
        tick("jal_halt", ex(32'h20, 1'b1, 32'd12, 16'd0, 16'd0));

        // ---- reset while halted and with a halt request pending ----
        drive(F_ECALL, 32'd0, 32'd0, 32'd10, 1'b0, 1'b0);
        rst = 1'b1;
        tick("rst_halt", ex(32'h0, 1'b0, 32'd0, 16'd0, 16'd0));
        rst = 1'b0;
        drive(8'h00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        // ---- jump counter saturation, then reset mid-stream ----
        do_reset();
        drive(F_JAL, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (65535) @(posedge clk);
        #1;
        chk_state("sat_pre", ex(32'h3FFFC, 1'b0, 32'd65535, 16'hFFFF, 16'd0));
        @(negedge clk);
        tick("sat", ex(32'h40000, 1'b0, 32'd65536, 16'hFFFF, 16'd0));
        rst = 1'b1;
        tick("sat_rst", ex(32'h0, 1'b0, 32'd0, 16'd0, 16'd0));
        rst = 1'b0;
        tick("post_rst", ex(32'h4, 1'b0, 32'd1, 16'd1, 16'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
